// File: rtl/tagger_pkg.sv
// tagger_pkg: shared conf encoding, partition-table entry type and NAPOT mask helper
// Provides TAGGER_TAB_T(PL): packed entry {addr[33:0], patid[PL-1:0], conf[1:0]}.
`define TAGGER_TAB_T(PL) struct packed { logic [33:0] addr; logic [(PL)-1:0] patid; logic [1:0] conf; }

package tagger_pkg;

    typedef enum logic [1:0] {
        CONF_OFF   = 2'b00,
        CONF_TOR   = 2'b01,
        CONF_NA4   = 2'b10,
        CONF_NAPOT = 2'b11
    } tagger_conf_e;

    // Ones mark the byte-address bits compared for a NAPOT region. The trailing
    // ones of the word field plus the lowest zero become don't-care, together with byte bits [1:0].
    function automatic logic [33:0] napot_mask(input logic [31:0] e);
        logic [31:0] m;
        m = e ^ (e + 32'd1);
        return ~{m, 2'b11};
    endfunction

endpackage

// File: rtl/tagger_range_cmp.sv
// tagger_range_cmp: combinational PMP-style compare of one address against one table entry
// Ports: addr_i request byte address [33:0]; entry_i table entry; prev_addr_i word address field of entry k-1 (0 for k=0); match_o entry matches.
module tagger_range_cmp
    import tagger_pkg::*;
#(
    parameter int  PATID_LEN = 8,
    parameter type tag_tab_t = `TAGGER_TAB_T(PATID_LEN)
) (
    input  logic [33:0] addr_i,
    input  tag_tab_t    entry_i,
    input  logic [31:0] prev_addr_i,
    output logic        match_o
);
    tagger_conf_e conf;
    logic [33:0]  hi;
    logic [33:0]  lo;
    logic         tor_hit;
    logic         na4_hit;
    logic         napot_hit;
    logic         unused;

    assign conf      = tagger_conf_e'(entry_i.conf);
    assign hi        = {entry_i.addr[31:0], 2'b00};
    assign lo        = {prev_addr_i, 2'b00};
    assign tor_hit   = (lo < hi) && (addr_i >= lo) && (addr_i < hi);
    assign na4_hit   = addr_i[33:2] == entry_i.addr[31:0];
    assign napot_hit = ((addr_i ^ hi) & napot_mask(entry_i.addr[31:0])) == '0;
    assign unused    = ^{entry_i.patid, entry_i.addr[33:32]};

    always_comb begin
        match_o = (conf == CONF_TOR)   ? tor_hit :
                  (conf == CONF_NA4)   ? na4_hit :
                  (conf == CONF_NAPOT) ? napot_hit : 1'b0;
    end

endmodule

// File: rtl/tagger_addr_matcher.sv
// tagger_addr_matcher: tags an AXI Ax request with the partition ID of the winning table entry
// Ports: clk_i/rst_i (sync, active-high); tag_tab_i committed partition table; req_* upstream Ax request;
// out_* registered tagged request with hit flag and winning index.
// Optional macro TAGGER_MATCH_STATS_EN adds clr_cnt_i and per-entry saturating hit counters hit_cnt_o.
module tagger_addr_matcher
    import tagger_pkg::*;
#(
    parameter int                  MAXPARTITION  = 2,
    parameter int                  PATID_LEN     = 8,
    parameter int                  ADDR_WIDTH    = 48,
    parameter int                  USER_WIDTH    = 16,
    parameter int                  USER_ID_LSB   = 0,
    parameter int                  PAYLOAD_WIDTH = 64,
    parameter logic [PATID_LEN-1:0] DEFAULT_PATID = '0,
    parameter type                 tag_tab_t     = `TAGGER_TAB_T(PATID_LEN),
    localparam int                 IDX_W         = (MAXPARTITION > 1) ? $clog2(MAXPARTITION) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
`ifdef TAGGER_MATCH_STATS_EN
    input  logic                               clr_cnt_i,
    output logic [MAXPARTITION-1:0][31:0]      hit_cnt_o,
`endif
    input  tag_tab_t [MAXPARTITION-1:0]        tag_tab_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [ADDR_WIDTH-1:0]              req_addr_i,
    input  logic [USER_WIDTH-1:0]              req_user_i,
    input  logic [PAYLOAD_WIDTH-1:0]           req_payload_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [ADDR_WIDTH-1:0]              out_addr_o,
    output logic [USER_WIDTH-1:0]              out_user_o,
    output logic [PAYLOAD_WIDTH-1:0]           out_payload_o,
    output logic                               out_hit_o,
    output logic [IDX_W-1:0]                   out_hit_idx_o
);
    logic [MAXPARTITION-1:0]  match;
    logic                     addr_ok;
    logic                     hit;
    logic [IDX_W-1:0]         idx;
    logic [PATID_LEN-1:0]     patid;
    logic [USER_WIDTH-1:0]    user_tag;
    logic                     accept;
    logic                     full_q, full_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [USER_WIDTH-1:0]    user_q, user_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
    logic                     hit_q, hit_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    // Addresses beyond the 34-bit table space never match any entry.
    assign addr_ok = (req_addr_i >> 34) == '0;

    for (genvar k = 0; k < MAXPARTITION; k++) begin : g_cmp
        logic [31:0] prev;
        if (k == 0) begin : g_first
            assign prev = '0;
        end else begin : g_rest
            assign prev = tag_tab_i[k-1].addr[31:0];
        end
        tagger_range_cmp #(
            .PATID_LEN (PATID_LEN),
            .tag_tab_t (tag_tab_t)
        ) u_cmp (
            .addr_i      (req_addr_i[33:0]),
            .entry_i     (tag_tab_i[k]),
            .prev_addr_i (prev),
            .match_o     (match[k])
        );
    end

    // Scan from the top down so the lowest-indexed match is the last one written.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        patid = DEFAULT_PATID;
        for (int k = MAXPARTITION - 1; k >= 0; k--) begin
            if (addr_ok && match[k]) begin
                hit   = 1'b1;
                idx   = IDX_W'(k);
                patid = tag_tab_i[k].patid;
            end
        end
    end

    always_comb begin
        user_tag                           = req_user_i;
        user_tag[USER_ID_LSB +: PATID_LEN] = patid;
    end

    assign req_ready_o = !full_q || out_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        full_d    = accept ? 1'b1 : (out_ready_i ? 1'b0 : full_q);
        addr_d    = accept ? req_addr_i    : addr_q;
        user_d    = accept ? user_tag      : user_q;
        payload_d = accept ? req_payload_i : payload_q;
        hit_d     = accept ? hit           : hit_q;
        idx_d     = accept ? idx           : idx_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q    <= 1'b0;
            addr_q    <= '0;
            user_q    <= '0;
            payload_q <= '0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
        end else begin
            full_q    <= full_d;
            addr_q    <= addr_d;
            user_q    <= user_d;
            payload_q <= payload_d;
            hit_q     <= hit_d;
            idx_q     <= idx_d;
        end
    end

    assign out_valid_o   = full_q;
    assign out_addr_o    = addr_q;
    assign out_user_o    = user_q;
    assign out_payload_o = payload_q;
    assign out_hit_o     = hit_q;
    assign out_hit_idx_o = idx_q;

`ifdef TAGGER_MATCH_STATS_EN
    logic [MAXPARTITION-1:0][31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < MAXPARTITION; k++) begin
            cnt_d[k] = clr_cnt_i ? 32'd0 :
                       (accept && hit && idx == IDX_W'(k) && cnt_q[k] != '1) ? cnt_q[k] + 32'd1 : cnt_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_tagger_addr_matcher.sv
// tb_tagger_addr_matcher: directed table-driven checks of tagging, priority, handshake and reset
module tb_tagger_addr_matcher;

    typedef struct packed {
        logic [33:0] addr;
        logic [7:0]  patid;
        logic [1:0]  conf;
    } tab_t;

    typedef struct {
        logic [1:0]  c0;
        logic [33:0] a0;
        logic [7:0]  p0;
        logic [1:0]  c1;
        logic [33:0] a1;
        logic [7:0]  p1;
        logic [47:0] addr;
        logic [15:0] user;
        logic [15:0] euser;
        logic        ehit;
        logic        eidx;
    } vec_t;

    localparam logic [1:0] OFF = 2'b00, TOR = 2'b01, NA4 = 2'b10, NAP = 2'b11;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    tab_t [1:0]        tab;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [47:0]       req_addr = '0;
    logic [15:0]       req_user = '0;
    logic [63:0]       req_payload = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [47:0]       out_addr;
    logic [15:0]       out_user;
    logic [63:0]       out_payload;
    logic              out_hit;
    logic              out_idx;
`ifdef TAGGER_MATCH_STATS_EN
    logic              clr = 1'b0;
    logic [1:0][31:0]  cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    tagger_addr_matcher #(
        .DEFAULT_PATID (8'h5A)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
`ifdef TAGGER_MATCH_STATS_EN
        .clr_cnt_i     (clr),
        .hit_cnt_o     (cnt),
`endif
        .tag_tab_i     (tab),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_user_i    (req_user),
        .req_payload_i (req_payload),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_addr_o    (out_addr),
        .out_user_o    (out_user),
        .out_payload_o (out_payload),
        .out_hit_o     (out_hit),
        .out_hit_idx_o (out_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_tab(input logic [1:0] c0, input logic [33:0] a0, input logic [7:0] p0,
                           input logic [1:0] c1, input logic [33:0] a1, input logic [7:0] p1);
        tab[0] = '{addr: a0, patid: p0, conf: c0};
        tab[1] = '{addr: a1, patid: p1, conf: c1};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{OFF, 34'h0,        8'h00, OFF, 34'h0,   8'h00, 48'h1000,        16'hFF00, 16'hFF5A, 1'b0, 1'b0},
            '{TOR, 34'h400,      8'h11, OFF, 34'h0,   8'h00, 48'h0FFC,        16'hFF00, 16'hFF11, 1'b1, 1'b0},
            '{TOR, 34'h400,      8'h11, OFF, 34'h0,   8'h00, 48'h1000,        16'hFF00, 16'hFF5A, 1'b0, 1'b0},
            '{TOR, 34'h400,      8'h11, OFF, 34'h0,   8'h00, 48'h0000,        16'h1234, 16'h1211, 1'b1, 1'b0},
            '{NAP, 34'h3FF,      8'h22, NA4, 34'h400, 8'h33, 48'h1000,        16'hFF00, 16'hFF22, 1'b1, 1'b0},
            '{OFF, 34'h3FF,      8'h22, NA4, 34'h400, 8'h33, 48'h1000,        16'hFF00, 16'hFF33, 1'b1, 1'b1},
            '{OFF, 34'h3FF,      8'h22, NA4, 34'h400, 8'h33, 48'h1003,        16'hAB00, 16'hAB33, 1'b1, 1'b1},
            '{OFF, 34'h3FF,      8'h22, NA4, 34'h400, 8'h33, 48'h1004,        16'hFF00, 16'hFF5A, 1'b0, 1'b0},
            '{NAP, 34'h3FF,      8'h22, OFF, 34'h0,   8'h00, 48'h1FFF,        16'hFF00, 16'hFF22, 1'b1, 1'b0},
            '{NAP, 34'h3FF,      8'h22, OFF, 34'h0,   8'h00, 48'h2000,        16'hFF00, 16'hFF5A, 1'b0, 1'b0},
            '{NAP, 34'hFFFFFFFF, 8'h22, OFF, 34'h0,   8'h00, 48'h3_FFFF_FFFC, 16'hFF00, 16'hFF22, 1'b1, 1'b0},
            '{NAP, 34'hFFFFFFFF, 8'h22, OFF, 34'h0,   8'h00, 48'h4_0000_0000, 16'hFF00, 16'hFF5A, 1'b0, 1'b0},
            '{OFF, 34'h400,      8'h11, TOR, 34'h800, 8'h44, 48'h1000,        16'hFF00, 16'hFF44, 1'b1, 1'b1},
            '{OFF, 34'h400,      8'h11, TOR, 34'h800, 8'h44, 48'h0FFC,        16'hFF00, 16'hFF5A, 1'b0, 1'b0},
            '{OFF, 34'h400,      8'h11, TOR, 34'h800, 8'h44, 48'h1FFC,        16'hFF00, 16'hFF44, 1'b1, 1'b1},
            '{OFF, 34'h400,      8'h11, TOR, 34'h800, 8'h44, 48'h2000,        16'hFF00, 16'hFF5A, 1'b0, 1'b0},
            '{OFF, 34'h800,      8'h11, TOR, 34'h400, 8'h44, 48'h1000,        16'hFF00, 16'hFF5A, 1'b0, 1'b0}
        };
        set_tab(OFF, 0, 0, OFF, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_user", 64'(out_user), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            set_tab(vecs[i].c0, vecs[i].a0, vecs[i].p0, vecs[i].c1, vecs[i].a1, vecs[i].p1);
            req_addr    = vecs[i].addr;
            req_user    = vecs[i].user;
            req_payload = 64'hC0DE_0000_0000_0000 | 64'(i);
            req_valid   = 1'b1;
            out_ready   = 1'b1;
            tick();
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_user", i), 64'(out_user), 64'(vecs[i].euser));
            chk($sformatf("v%0d_hit", i), 64'(out_hit), 64'(vecs[i].ehit));
            chk($sformatf("v%0d_idx", i), 64'(out_idx), 64'(vecs[i].eidx));
            chk($sformatf("v%0d_addr", i), 64'(out_addr), 64'(vecs[i].addr));
            chk($sformatf("v%0d_payload", i), out_payload, 64'hC0DE_0000_0000_0000 | 64'(i));
        end
        @(negedge clk);
        req_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // backpressure: held request stays stable, table change after accept is ignored
        @(negedge clk);
        set_tab(OFF, 0, 0, OFF, 0, 0);
        req_addr  = 48'h100;
        req_user  = 16'hFF00;
        req_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        req_addr = 48'h200;
        set_tab(NAP, 34'hFFFFFFFF, 8'h22, OFF, 0, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("bp%0d_ready", c), 64'(req_ready), 64'd0);
            chk($sformatf("bp%0d_addr", c), 64'(out_addr), 64'h100);
            chk($sformatf("bp%0d_user", c), 64'(out_user), 64'hFF5A);
            chk($sformatf("bp%0d_hit", c), 64'(out_hit), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_rise", 64'(req_ready), 64'd1);
        tick();
        chk("bp_a2_valid", 64'(out_valid), 64'd1);
        chk("bp_a2_addr", 64'(out_addr), 64'h200);
        chk("bp_a2_user", 64'(out_user), 64'hFF22);
        @(negedge clk);
        req_addr = 48'h300;
        tick();
        chk("bp_a3_addr", 64'(out_addr), 64'h300);
        @(negedge clk);
        req_valid = 1'b0;
        tick();
        chk("bp_end_valid", 64'(out_valid), 64'd0);

        // reset while full and stalled
        @(negedge clk);
        req_addr  = 48'h1234;
        req_user  = 16'h00FF;
        req_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("rs_full", 64'(out_valid), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();
        chk("rs_valid", 64'(out_valid), 64'd0);
        chk("rs_addr", 64'(out_addr), 64'd0);
        chk("rs_user", 64'(out_user), 64'd0);
        chk("rs_payload", out_payload, 64'd0);
        chk("rs_hit", 64'(out_hit), 64'd0);
        chk("rs_idx", 64'(out_idx), 64'd0);
        chk("rs_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;

`ifdef TAGGER_MATCH_STATS_EN
        chk("cnt_rst", 64'(cnt[1]), 64'd0);
        set_tab(OFF, 0, 0, NA4, 34'h400, 8'h33);
        req_addr  = 48'h1000;
        req_valid = 1'b1;
        repeat (5) tick();
        chk("cnt1_5", 64'(cnt[1]), 64'd5);
        chk("cnt0_0", 64'(cnt[0]), 64'd0);
        @(negedge clk);
        clr = 1'b1;
        tick();
        chk("cnt1_clr", 64'(cnt[1]), 64'd0);
        @(negedge clk);
        clr       = 1'b0;
        req_valid = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
